// File: rtl/light_pkg.sv
// Shared types for the bike light sequencer.
// Mode encoding and the mode-advance sequence.
package light_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_FLASH_1 = 2'd2,
    MODE_FLASH_2 = 2'd3
  } mode_e;

  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    unique case (m)
      MODE_OFF:     n = MODE_ON;
      MODE_ON:      n = MODE_FLASH_1;
      MODE_FLASH_1: n = MODE_FLASH_2;
      default:      n = MODE_OFF;
    endcase
    return n;
  endfunction

  function automatic logic is_flash(input mode_e m);
    return (m == MODE_FLASH_1) || (m == MODE_FLASH_2);
  endfunction

endpackage

// File: rtl/beat_countdown.sv
// Loadable down-counter stepped by count_en, saturating at zero.
// A load in the same cycle as count_en wins.
module beat_countdown #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         count_en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         nonzero
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: load, else step down while nonzero
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (count_en && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  // count register, cleared by reset
  always_ff @(posedge clk) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/light_mode_controller.sv
// Bike light mode FSM and blinker speed-adjust router.
// LIGHT_AUTO_OFF_EN adds an idle timer forcing OFF.
module light_mode_controller
  import light_pkg::*;
#(
  parameter int HOLD_BEATS = 4,
  parameter int IDLE_BEATS = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       count_en,
  input  logic       mode_btn,
  input  logic       left_btn,
  input  logic       right_btn,
  output logic       shift_left_1,
  output logic       shift_right_1,
  output logic       shift_left_2,
  output logic       shift_right_2,
  output logic [1:0] mode,
  output logic       blink_restart,
  output logic       busy
);

  localparam int LW =
    (HOLD_BEATS < 1) ? 1 : $clog2(HOLD_BEATS + 1);

  mode_e      mode_q, mode_d;
  logic       restart_q, restart_d;
  logic       taken_q, taken_d;
  logic [3:0] strb_q, strb_d;
  logic       idle_expire;
  logic       mode_chg;
  logic       lock_nz;
  logic       accept;

`ifdef LIGHT_AUTO_OFF_EN
  localparam int IW =
    (IDLE_BEATS < 1) ? 1 : $clog2(IDLE_BEATS + 1);

  logic any_btn;
  logic idle_nz;
  logic idle_load;

  assign any_btn = mode_btn | left_btn | right_btn;
  assign idle_expire = !idle_nz && !any_btn &&
                       (mode_q != MODE_OFF);
  assign idle_load = any_btn | idle_expire |
                     (mode_q == MODE_OFF);

  beat_countdown #(.W(IW)) u_idle (
    .clk      (clk),
    .reset    (reset),
    .count_en (count_en),
    .load     (idle_load),
    .load_val (IW'(IDLE_BEATS)),
    .nonzero  (idle_nz)
  );
`else
  logic [31:0] idle_unused;

  assign idle_unused = IDLE_BEATS;
  assign idle_expire = 1'b0;
`endif

  assign mode_chg = mode_btn | idle_expire;

  beat_countdown #(.W(LW)) u_lock (
    .clk      (clk),
    .reset    (reset),
    .count_en (count_en),
    .load     (mode_chg),
    .load_val (LW'(HOLD_BEATS)),
    .nonzero  (lock_nz)
  );

  // next mode, restart pulse, request acceptance and routing
  always_comb begin
    mode_d    = mode_q;
    restart_d = 1'b0;
    taken_d   = taken_q;
    strb_d    = '0;
    accept    = is_flash(mode_q) && !lock_nz &&
                !mode_btn && (left_btn ^ right_btn) &&
                !taken_q;
    if (mode_btn) begin
      mode_d    = next_mode(mode_q);
      restart_d = is_flash(mode_d);
    end else if (idle_expire) begin
      mode_d = MODE_OFF;
    end
    if (count_en)
      taken_d = 1'b0;
    if (accept) begin
      taken_d = 1'b1;
      if (mode_q == MODE_FLASH_1)
        strb_d = {left_btn, right_btn, 2'b00};
      else
        strb_d = {2'b00, left_btn, right_btn};
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q    <= MODE_OFF;
      restart_q <= 1'b0;
      taken_q   <= 1'b0;
      strb_q    <= '0;
    end else begin
      mode_q    <= mode_d;
      restart_q <= restart_d;
      taken_q   <= taken_d;
      strb_q    <= strb_d;
    end
  end

  assign shift_left_1  = strb_q[3];
  assign shift_right_1 = strb_q[2];
  assign shift_left_2  = strb_q[1];
  assign shift_right_2 = strb_q[0];
  assign mode          = mode_q;
  assign blink_restart = restart_q;
  assign busy          = lock_nz;

endmodule

// File: tb/tb_light_mode_controller.sv
// Directed bench for light_mode_controller.
// Auto-off section runs when LIGHT_AUTO_OFF_EN is defined.
module tb_light_mode_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       count_en = 1'b0;
  logic       mode_btn = 1'b0;
  logic       left_btn = 1'b0;
  logic       right_btn = 1'b0;
  logic       shift_left_1, shift_right_1;
  logic       shift_left_2, shift_right_2;
  logic [1:0] mode;
  logic       blink_restart;
  logic       busy;
  logic [3:0] strb;

  int n_chk = 0;
  int n_pass = 0;

  light_mode_controller #(
    .HOLD_BEATS (4),
    .IDLE_BEATS (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .count_en      (count_en),
    .mode_btn      (mode_btn),
    .left_btn      (left_btn),
    .right_btn     (right_btn),
    .shift_left_1  (shift_left_1),
    .shift_right_1 (shift_right_1),
    .shift_left_2  (shift_left_2),
    .shift_right_2 (shift_right_2),
    .mode          (mode),
    .blink_restart (blink_restart),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  assign strb = {shift_left_1, shift_right_1,
                 shift_left_2, shift_right_2};

  task automatic chk(input string tag,
                     input logic [3:0] got,
                     input logic [3:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
  endtask

  // apply inputs for one cycle, then release
  task automatic drive(input logic m, input logic l,
                       input logic r, input logic ce);
    mode_btn  = m;
    left_btn  = l;
    right_btn = r;
    count_en  = ce;
    @(posedge clk);
    #1;
    mode_btn  = 1'b0;
    left_btn  = 1'b0;
    right_btn = 1'b0;
    count_en  = 1'b0;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++)
      drive(0, 0, 0, 1);
  endtask

  logic [1:0] exp_m;

  initial begin
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("rst_mode", {2'b0, mode}, 4'd0);
    chk("rst_strb", strb, 4'b0000);
    chk("rst_rst", {3'b0, blink_restart}, 4'd0);
    chk("rst_busy", {3'b0, busy}, 4'd0);
    reset = 1'b1;

    // full mode cycle, 10 cycles apart
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      exp_m = 2'(i + 1);
      chk("cyc_mode", {2'b0, mode}, {2'b0, exp_m});
      chk("cyc_rst", {3'b0, blink_restart},
          {3'b0, exp_m[1]});
      chk("cyc_busy", {3'b0, busy}, 4'd1);
      drive(0, 0, 0, 0);
      chk("cyc_rst_end", {3'b0, blink_restart}, 4'd0);
      for (int k = 0; k < 8; k++)
        drive(0, 0, 0, 0);
    end

    // FLASH_1: lockout then single left shift
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("f1_mode", {2'b0, mode}, 4'd2);
    chk("f1_rst", {3'b0, blink_restart}, 4'd1);
    beats(3);
    chk("f1_busy3", {3'b0, busy}, 4'd1);
    beats(1);
    chk("f1_busy4", {3'b0, busy}, 4'd0);
    drive(0, 1, 0, 0);
    chk("f1_sl1", strb, 4'b1000);
    drive(0, 0, 0, 0);
    chk("f1_sl1_end", strb, 4'b0000);

    // one adjustment per beat
    beats(1);
    drive(0, 1, 0, 0);
    chk("rate_1", strb, 4'b1000);
    drive(0, 1, 0, 0);
    chk("rate_2", strb, 4'b0000);
    drive(0, 1, 0, 0);
    chk("rate_3", strb, 4'b0000);
    beats(1);
    chk("rate_beat", strb, 4'b0000);
    drive(0, 1, 0, 0);
    chk("rate_next", strb, 4'b1000);

    // accept coinciding with count_en keeps flag set
    beats(1);
    drive(0, 1, 0, 1);
    chk("co_acc", strb, 4'b1000);
    drive(0, 1, 0, 0);
    chk("co_held", strb, 4'b0000);

    // both buttons dropped without taking the beat
    beats(1);
    drive(0, 1, 1, 0);
    chk("both", strb, 4'b0000);
    drive(0, 0, 1, 0);
    chk("f1_sr1", strb, 4'b0100);

    // FLASH_2: request during lockout dropped
    drive(1, 0, 0, 0);
    chk("f2_mode", {2'b0, mode}, 4'd3);
    chk("f2_rst", {3'b0, blink_restart}, 4'd1);
    drive(0, 1, 0, 0);
    chk("f2_lock", strb, 4'b0000);
    chk("f2_busy", {3'b0, busy}, 4'd1);
    beats(3);
    chk("f2_busy3", {3'b0, busy}, 4'd1);
    beats(1);
    chk("f2_busy4", {3'b0, busy}, 4'd0);
    drive(0, 0, 1, 0);
    chk("f2_sr2", strb, 4'b0001);

    // request with mode_btn: no strobe, mode advances
    beats(1);
    drive(1, 1, 0, 0);
    chk("mb_strb", strb, 4'b0000);
    chk("mb_mode", {2'b0, mode}, 4'd0);
    chk("mb_rst", {3'b0, blink_restart}, 4'd0);

    // OFF ignores requests
    beats(4);
    drive(0, 1, 0, 0);
    chk("off_strb", strb, 4'b0000);

    // load beats a coincident count_en
    drive(1, 0, 0, 1);
    chk("lw_mode", {2'b0, mode}, 4'd1);
    beats(3);
    chk("lw_busy3", {3'b0, busy}, 4'd1);
    beats(1);
    chk("lw_busy4", {3'b0, busy}, 4'd0);
    drive(0, 0, 1, 0);
    chk("on_strb", strb, 4'b0000);

    // reset while a strobe is out
    drive(1, 0, 0, 0);
    beats(4);
    drive(0, 1, 0, 0);
    chk("pre_rst", strb, 4'b1000);
    reset = 1'b0;
    drive(0, 0, 0, 0);
    chk("mr_strb", strb, 4'b0000);
    chk("mr_mode", {2'b0, mode}, 4'd0);
    chk("mr_busy", {3'b0, busy}, 4'd0);
    chk("mr_rst", {3'b0, blink_restart}, 4'd0);
    reset = 1'b1;

`ifdef LIGHT_AUTO_OFF_EN
    drive(1, 0, 0, 0);
    beats(4);
    beats(3);
    drive(0, 1, 0, 0);
    beats(7);
    chk("ao_kept", {2'b0, mode}, 4'd1);
    beats(1);
    chk("ao_reach", {2'b0, mode}, 4'd1);
    drive(0, 0, 0, 0);
    chk("ao_off", {2'b0, mode}, 4'd0);
    chk("ao_busy", {3'b0, busy}, 4'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
